// File: rtl/noise_ctrl.sv
// Control plane for the noise channel: frame-sequencer step, length counter,
// envelope step timing and the OFF/START/ON channel FSM with restart pulse.
module noise_ctrl #(
  parameter int RESTART_CYCLES = 3
) (
  input  logic       dova_phi,
  input  logic       napu_reset,
  input  logic       fs_tick,
  input  logic       wr_nr41,
  input  logic       wr_nr42,
  input  logic       wr_nr44,
  input  logic [7:0] d_in,
  output logic       ch4_restart,
  output logic       ch4_eg_tick,
  output logic       ch4_active,
  output logic [6:0] len_cnt,
  output logic [2:0] fs_step
);

  typedef enum logic [1:0] {ST_OFF, ST_START, ST_ON} state_t;

  localparam logic [2:0] RS_LOAD = 3'(RESTART_CYCLES);

  state_t     state_q, state_d;
  logic [2:0] rs_cnt_q, rs_cnt_d;
  logic [2:0] fs_step_q, fs_step_d;
  logic [6:0] len_cnt_q, len_cnt_d;
  logic       len_en_q, len_en_d;
  logic       dac_on_q, dac_on_d;
  logic [2:0] env_per_q, env_per_d;
  logic [2:0] env_cnt_q, env_cnt_d;
  logic       restart_q, restart_d;
  logic       active_q, active_d;
  logic       eg_tick_q, eg_tick_d;

  logic       step_odd, len_clk, env_clk, trig, dac_kill;
  logic       len_dec, len_expire;
  logic [6:0] len_after;

  always_comb begin
    step_odd   = fs_step_q[0];
    // Both sequencer clocks are swallowed while the datapath is being restarted
    len_clk    = fs_tick & ~step_odd & ~restart_q;
    env_clk    = fs_tick & (fs_step_q == 3'd7) & ~restart_q;
    trig       = wr_nr44 & d_in[7];
    dac_kill   = wr_nr42 & (d_in[7:3] == 5'd0);
    len_dec    = (len_cnt_q != 7'd0) &
                 ((len_clk & len_en_q) | (wr_nr44 & ~len_en_q & d_in[6] & step_odd));
    len_after  = len_cnt_q - 7'(len_dec);
    len_expire = len_dec & (len_after == 7'd0) & ~wr_nr41 & ~trig;

    fs_step_d  = fs_tick ? fs_step_q + 3'd1 : fs_step_q;
    len_en_d   = wr_nr44 ? d_in[6] : len_en_q;
    dac_on_d   = wr_nr42 ? (d_in[7:3] != 5'd0) : dac_on_q;
    env_per_d  = wr_nr42 ? d_in[2:0] : env_per_q;

    // A length write overrides any clocking that lands in the same cycle
    if (wr_nr41) begin
      len_cnt_d = 7'd64 - {1'b0, d_in[5:0]};
    end else if (trig && (len_after == 7'd0)) begin
      len_cnt_d = (d_in[6] && step_odd) ? 7'd63 : 7'd64;
    end else begin
      len_cnt_d = len_after;
    end

    env_cnt_d = env_cnt_q;
    eg_tick_d = 1'b0;
    if (trig) begin
      env_cnt_d = env_per_q;
    end else if (env_clk && active_q && (env_per_q != 3'd0)) begin
      if (env_cnt_q == 3'd1) begin
        env_cnt_d = env_per_q;
        eg_tick_d = 1'b1;
      end else begin
        env_cnt_d = env_cnt_q - 3'd1;
      end
    end

    state_d  = state_q;
    rs_cnt_d = rs_cnt_q;
    if (state_q == ST_START) begin
      if (rs_cnt_q == 3'd1) begin
        state_d  = ST_ON;
        rs_cnt_d = 3'd0;
      end else begin
        rs_cnt_d = rs_cnt_q - 3'd1;
      end
    end
    if (len_expire) begin
      state_d  = ST_OFF;
      rs_cnt_d = 3'd0;
    end
    if (trig && dac_on_q) begin
      state_d  = ST_START;
      rs_cnt_d = RS_LOAD;
    end
    if (dac_kill) begin
      state_d  = ST_OFF;
      rs_cnt_d = 3'd0;
    end

    restart_d = (state_d == ST_START);
    active_d  = (state_d != ST_OFF);
  end

  always_ff @(posedge dova_phi) begin
    if (!napu_reset) begin
      state_q   <= ST_OFF;
      rs_cnt_q  <= 3'd0;
      fs_step_q <= 3'd0;
      len_cnt_q <= 7'd0;
      len_en_q  <= 1'b0;
      dac_on_q  <= 1'b0;
      env_per_q <= 3'd0;
      env_cnt_q <= 3'd0;
      restart_q <= 1'b0;
      active_q  <= 1'b0;
      eg_tick_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rs_cnt_q  <= rs_cnt_d;
      fs_step_q <= fs_step_d;
      len_cnt_q <= len_cnt_d;
      len_en_q  <= len_en_d;
      dac_on_q  <= dac_on_d;
      env_per_q <= env_per_d;
      env_cnt_q <= env_cnt_d;
      restart_q <= restart_d;
      active_q  <= active_d;
      eg_tick_q <= eg_tick_d;
    end
  end

  assign ch4_restart = restart_q;
  assign ch4_eg_tick = eg_tick_q;
  assign ch4_active  = active_q;
  assign len_cnt     = len_cnt_q;
  assign fs_step     = fs_step_q;

endmodule

// File: doc/noise_ctrl.md
NOISE_CTRL -- requirements
Module: noise_ctrl

Interface
REQ-001 Parameter RESTART_CYCLES, default 3, number of dova_phi cycles the ch4_restart pulse is held high (legal range 1..7).
REQ-002 dova_phi  input  1  sole clock; all state updates on its rising edge.
REQ-003 napu_reset  input  1  reset, synchronous, active-low.
REQ-004 fs_tick  input  1  one-cycle 512 Hz frame-sequencer strobe.
REQ-005 wr_nr41, wr_nr42, wr_nr44  input  1 each  one-cycle register write strobes.
REQ-006 d_in  input  8  CPU write data, sampled when any wr_* strobe is high.
REQ-007 ch4_restart  output  1  restart pulse to the noise datapath (LFSR, envelope and divider reset).
REQ-008 ch4_eg_tick  output  1  one-cycle envelope step strobe.
REQ-009 ch4_active  output  1  channel-enabled status (NR52 bit 3).
REQ-010 len_cnt  output  7  remaining length, 0..64.
REQ-011 fs_step  output  3  current frame-sequencer step.

Function
REQ-012 Frame-sequencer step counter: on fs_tick, fs_step increments modulo 8 (7 wraps to 0).
REQ-013 Length clock: fs_tick while the pre-increment fs_step is even (0, 2, 4 or 6).
REQ-014 Envelope clock: fs_tick while the pre-increment fs_step == 7.
REQ-015 NR41 write: len_cnt <= 64 - d_in[5:0]; value is 64 for d_in[5:0] = 0 and 1 for 63.
REQ-016 NR42 write: store dac_on = |d_in[7:3] and env_period = d_in[2:0].
REQ-017 A NR42 write with d_in[7:3] = 0 clears ch4_active in the same cycle and aborts any restart in progress.
REQ-018 NR44 write: store len_en = d_in[6]; d_in[7] = 1 is a trigger.
REQ-019 On a length clock with len_en = 1 and len_cnt != 0, len_cnt decrements.
REQ-020 When that decrement reaches 0, ch4_active clears in the same update.
REQ-021 Extra clock: a NR44 write that changes len_en from 0 to 1 while fs_step is odd and len_cnt != 0 decrements len_cnt once.
REQ-022 If the extra clock reaches 0 and d_in[7] = 0, ch4_active clears.
REQ-023 Trigger with len_cnt = 0 reloads len_cnt to 64.
REQ-024 Trigger reload value is 63 instead of 64 if the new len_en = 1 and fs_step is odd.
REQ-025 Trigger with len_cnt != 0 leaves len_cnt unchanged, except for the extra clock of REQ-021.
REQ-026 FSM states: OFF (ch4_active = 0), START (restart counter running), ON (ch4_active = 1).
REQ-027 OFF/ON -> START on a trigger with dac_on = 1; ch4_restart rises on the next edge and stays high for exactly RESTART_CYCLES cycles.
REQ-028 START -> ON when the restart counter expires; ch4_active = 1 from the first START cycle.
REQ-029 A trigger with dac_on = 0 keeps the FSM in OFF, produces no ch4_restart and applies only the length reload.
REQ-030 A trigger during START restarts the restart counter; the pulse is extended, never split.
REQ-031 ON/START -> OFF on length expiry (REQ-020, REQ-022) or on DAC off (REQ-017).
REQ-032 If a length expiry and a trigger occur in the same cycle, the trigger wins.
REQ-033 Envelope period counter: 3 bits, loaded with env_period on trigger.
REQ-034 On each envelope clock while ch4_active = 1 and env_period != 0, the counter decrements.
REQ-035 When the envelope counter would go from 1 to 0, it reloads env_period and ch4_eg_tick pulses for one cycle.
REQ-036 With env_period = 0, ch4_eg_tick never pulses.
REQ-037 Length and envelope clocks are suppressed while ch4_restart = 1.
REQ-038 fs_step continues to advance while ch4_restart = 1.
REQ-039 Same-cycle NR41 write and length clock: the write wins and no decrement is applied.

Reset
REQ-040 With napu_reset = 0 at a clock edge, these registers clear to 0: fs_step, len_cnt, len_en, dac_on, env_period, envelope counter, restart counter.
REQ-041 Reset also forces FSM = OFF, ch4_restart = 0, ch4_eg_tick = 0 and ch4_active = 0.
REQ-042 Reset asserted during START terminates ch4_restart on that edge.
REQ-043 While napu_reset = 0, all strobes are ignored.

Verification
REQ-044 NR42 = 0xF3, NR41 = 0x3E, NR44 = 0xC0, 8 fs_ticks from step 0 -> ch4_restart high for 3 cycles; len_cnt 2 -> 1 -> 0 on steps 0 and 2; ch4_active falls at the second length clock.
REQ-045 NR42 = 0x08, len_cnt = 0, trigger with fs_step = 3 and d_in = 0xC0 -> len_cnt = 63, ch4_active = 1.
REQ-046 NR42 = 0x00, then NR44 = 0x80 -> no ch4_restart, ch4_active stays 0, len_cnt reloads to 64.
REQ-047 NR42 = 0xF2, trigger, 32 fs_ticks -> ch4_eg_tick pulses once per 2 envelope clocks (2 pulses total).
REQ-048 len_cnt = 1, len_en = 0, fs_step = 1, NR44 = 0x40 -> len_cnt = 0, ch4_active = 0 next cycle.
REQ-049 Trigger, then napu_reset = 0 on the 2nd restart cycle -> all outputs 0 on the next edge; a later trigger gives a full 3-cycle pulse.
